// File: rtl/bp_me_nonsynth_mem_responder.sv
// Behavioural CCE-side memory endpoint: block-granular backing store with programmable response latency.
// Define BP_ME_MEM_RESPONDER_RANDOM_LATENCY_EN to add 0-7 LFSR-driven extra wait cycles per command.
module bp_me_nonsynth_mem_responder
  #(parameter int unsigned paddr_width_p     = 40
  , parameter int unsigned cce_block_width_p = 512
  , parameter int unsigned dword_width_p     = 64
  , parameter int unsigned lce_id_width_p    = 4
  , parameter int unsigned lce_max_assoc_p   = 8
  , parameter int unsigned mem_els_p         = 256
  , parameter int unsigned latency_p         = 4
  , localparam int unsigned way_id_width_lp     = $clog2(lce_max_assoc_p)
  , localparam int unsigned cce_mem_hdr_width_lp =
      lce_id_width_p + way_id_width_lp + 3 + 1 + 3 + paddr_width_p + 4
  , localparam int unsigned cce_mem_msg_width_lp = cce_block_width_p + cce_mem_hdr_width_lp
  )
  (input  logic                            clk_i
  , input  logic                            reset_i
  , input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i
  , input  logic                            mem_cmd_v_i
  , output logic                            mem_cmd_ready_o
  , output logic [cce_mem_msg_width_lp-1:0] mem_resp_o
  , output logic                            mem_resp_v_o
  , input  logic                            mem_resp_yumi_i
  , output logic                            busy_o
  );

  localparam int unsigned lg_block_bytes_lp = $clog2(cce_block_width_p / 8);
  localparam int unsigned idx_width_lp      = $clog2(mem_els_p);
  localparam int unsigned dsel_width_lp     = $clog2(cce_block_width_p / dword_width_p);
  localparam int unsigned lg_dword_lp       = $clog2(dword_width_p);
  localparam int unsigned cnt_width_lp      = $clog2(latency_p + 8);

  typedef enum logic [3:0] {
    e_cce_mem_rd    = 4'd0,
    e_cce_mem_wr    = 4'd1,
    e_cce_mem_uc_rd = 4'd2,
    e_cce_mem_uc_wr = 4'd3,
    e_cce_mem_wb    = 4'd4
  } bp_cce_mem_cmd_type_e;

  typedef enum logic [1:0] {e_init, e_ready, e_wait, e_resp} state_e;

  if (latency_p == 0) begin : g_latency_chk
    $error("bp_me_nonsynth_mem_responder: latency_p must be at least 1");
  end

  logic [cce_block_width_p-1:0] mem_r [mem_els_p];

  state_e                            state_r, state_n;
  logic [idx_width_lp-1:0]           init_cnt_r;
  logic [cnt_width_lp-1:0]           wait_cnt_r, wait_load;
  logic [cce_mem_msg_width_lp-1:0]   resp_r;

  logic [3:0]                        cmd_type;
  logic [cce_mem_hdr_width_lp-1:0]   cmd_hdr;
  logic [cce_block_width_p-1:0]      cmd_data, rd_blk, resp_data;
  logic [idx_width_lp-1:0]           cmd_idx;
  logic [dsel_width_lp+lg_dword_lp-1:0] dword_lsb;
  logic                              accept;

  // Header layout from LSB: msg_type[3:0], addr, size, then payload; data sits above the header.
  assign cmd_type  = mem_cmd_i[3:0];
  assign cmd_hdr   = mem_cmd_i[cce_mem_hdr_width_lp-1:0];
  assign cmd_data  = mem_cmd_i[cce_mem_hdr_width_lp +: cce_block_width_p];
  assign cmd_idx   = mem_cmd_i[4 + lg_block_bytes_lp +: idx_width_lp];
  assign dword_lsb = {mem_cmd_i[4 + 3 +: dsel_width_lp], {lg_dword_lp{1'b0}}};
  assign accept    = (state_r == e_ready) && mem_cmd_v_i;
  assign rd_blk    = mem_r[cmd_idx];

  always_comb begin
    resp_data = '0;
    case (cmd_type)
      e_cce_mem_rd:    resp_data = rd_blk;
      e_cce_mem_uc_rd: resp_data = cce_block_width_p'(rd_blk[dword_lsb +: dword_width_p]);
      default:         resp_data = '0;
    endcase
  end

`ifdef BP_ME_MEM_RESPONDER_RANDOM_LATENCY_EN
  logic [15:0] lfsr_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) lfsr_r <= 16'hACE1;
    else         lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
  end

  assign wait_load = cnt_width_lp'(latency_p - 1) + cnt_width_lp'(lfsr_r[2:0]);
`else
  assign wait_load = cnt_width_lp'(latency_p - 1);
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= e_init;
    else         state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      e_init:  if (init_cnt_r == idx_width_lp'(mem_els_p - 1)) state_n = e_ready;
      e_ready: if (mem_cmd_v_i) state_n = e_wait;
      e_wait:  if (wait_cnt_r == '0) state_n = e_resp;
      e_resp:  if (mem_resp_yumi_i) state_n = e_ready;
      default: state_n = e_init;
    endcase
  end

  always_comb begin
    mem_cmd_ready_o = (state_r == e_ready);
    mem_resp_v_o    = (state_r == e_resp);
    busy_o          = (state_r != e_ready);
    mem_resp_o      = (state_r == e_resp) ? resp_r : '0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      init_cnt_r <= '0;
      wait_cnt_r <= '0;
      resp_r     <= '0;
    end else begin
      if (state_r == e_init) init_cnt_r <= init_cnt_r + 1'b1;
      if (accept) begin
        wait_cnt_r <= wait_load;
        resp_r     <= {resp_data, cmd_hdr};
      end else if ((state_r == e_wait) && (wait_cnt_r != '0)) begin
        wait_cnt_r <= wait_cnt_r - 1'b1;
      end
    end
  end

  // Store is not reset directly; the init sweep clears it after every reset.
  always_ff @(posedge clk_i) begin
    if (state_r == e_init) begin
      mem_r[init_cnt_r] <= '0;
    end else if (accept) begin
      case (cmd_type)
        e_cce_mem_wr, e_cce_mem_wb: mem_r[cmd_idx] <= cmd_data;
        e_cce_mem_uc_wr: mem_r[cmd_idx][dword_lsb +: dword_width_p] <= cmd_data[dword_width_p-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(mem_resp_yumi_i && !mem_resp_v_o))
        else $error("bp_me_nonsynth_mem_responder: mem_resp_yumi_i without mem_resp_v_o");
    end
  end

endmodule

// File: tb/tb_bp_me_nonsynth_mem_responder.sv
// Directed bench for bp_me_nonsynth_mem_responder: init sweep, latency, read/write types, aliasing, reset abort.
module tb_bp_me_nonsynth_mem_responder;

  localparam int MSG_W = 570;

`ifdef BP_ME_MEM_RESPONDER_RANDOM_LATENCY_EN
  localparam int LAT_MAX = 11;
`else
  localparam int LAT_MAX = 4;
`endif

  localparam logic [3:0] T_RD = 4'd0, T_WR = 4'd1, T_UC_RD = 4'd2, T_UC_WR = 4'd3, T_WB = 4'd4,
                         T_BAD = 4'hF;

  logic             clk = 1'b0;
  logic             reset;
  logic [MSG_W-1:0] mem_cmd;
  logic             cmd_v;
  logic             ready;
  logic [MSG_W-1:0] resp;
  logic             resp_v;
  logic             yumi;
  logic             busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [511:0] blk_d, blk_a, blk_b, blk_uc, blk_uc_rd, blk_uc_c0, ones;
  logic [63:0]  dw;

  always #5 clk = ~clk;

  bp_me_nonsynth_mem_responder #(.mem_els_p(256), .latency_p(4)) dut (
    .clk_i(clk), .reset_i(reset),
    .mem_cmd_i(mem_cmd), .mem_cmd_v_i(cmd_v), .mem_cmd_ready_o(ready),
    .mem_resp_o(resp), .mem_resp_v_o(resp_v), .mem_resp_yumi_i(yumi),
    .busy_o(busy)
  );

  // Message layout: {data, lce_id, way_id, state, speculative, size, addr, msg_type}
  function automatic logic [MSG_W-1:0] mk(input logic [3:0] t, input logic [39:0] a,
                                          input logic [3:0] lce, input logic [2:0] way,
                                          input logic [511:0] d);
    return {d, lce, way, 3'd0, 1'b0, 3'd6, a, t};
  endfunction

  task automatic check(input string tag, input logic [MSG_W-1:0] got, input logic [MSG_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(input string tag);
    int  c = 0;
    bit  v_seen = 1'b0;
    while (!ready && c < 400) begin
      if (resp_v) v_seen = 1'b1;
      tick();
      c++;
    end
    check({tag, ".cycles"}, MSG_W'(c), MSG_W'(256));
    check({tag, ".no_resp"}, MSG_W'(v_seen), MSG_W'(0));
  endtask

  task automatic xact(input string tag, input logic [MSG_W-1:0] cmd, input logic [MSG_W-1:0] exp,
                      input int hold);
    int c   = 0;
    int lat = 0;
    bit ready_low = 1'b1;
    bit stable    = 1'b1;
    while (!ready && c < 50) begin tick(); c++; end
    check({tag, ".ready"}, MSG_W'(ready), MSG_W'(1));
    mem_cmd = cmd;
    cmd_v   = 1'b1;
    tick();
    cmd_v   = 1'b0;
    mem_cmd = '0;
    while (!resp_v && lat < 50) begin
      if (ready) ready_low = 1'b0;
      tick();
      lat++;
    end
    if (LAT_MAX == 4) check({tag, ".lat"}, MSG_W'(lat), MSG_W'(4));
    else check({tag, ".lat_range"}, MSG_W'(lat >= 4 && lat <= LAT_MAX), MSG_W'(1));
    check({tag, ".ready_low"}, MSG_W'(ready_low), MSG_W'(1));
    check({tag, ".resp"}, resp, exp);
    for (int i = 0; i < hold; i++) begin
      tick();
      if (!resp_v || resp !== exp || ready) stable = 1'b0;
    end
    if (hold > 0) check({tag, ".hold_stable"}, MSG_W'(stable), MSG_W'(1));
    yumi = 1'b1;
    tick();
    yumi = 1'b0;
    check({tag, ".ready_after_yumi"}, MSG_W'(ready), MSG_W'(1));
  endtask

  initial begin
    reset = 1'b1; mem_cmd = '0; cmd_v = 1'b0; yumi = 1'b0;
    for (int i = 0; i < 8; i++) blk_d[i*64 +: 64] = {16'hDEAD, 16'(i), 16'h0000, 16'hBEEF};
    for (int i = 0; i < 8; i++) blk_a[i*64 +: 64] = {32'hAAAA_0000, 32'(i)};
    for (int i = 0; i < 8; i++) blk_b[i*64 +: 64] = {32'hBBBB_0000, 32'(i + 16)};
    dw        = 64'h1122_3344_5566_7788;
    ones      = '1;
    blk_uc    = {{56{8'hA5}}, dw};
    blk_uc_rd = '0;
    blk_uc_rd[63:0] = dw;
    blk_uc_c0 = '0;
    blk_uc_c0[127:64] = dw;

    repeat (3) tick();
    check("rst.ready", MSG_W'(ready), MSG_W'(0));
    check("rst.resp_v", MSG_W'(resp_v), MSG_W'(0));
    check("rst.resp", resp, MSG_W'(0));
    check("rst.busy", MSG_W'(busy), MSG_W'(1));
    reset = 1'b0;
    wait_init("init");
    check("init.busy", MSG_W'(busy), MSG_W'(0));

    xact("rd40", mk(T_RD, 40'h40, 4'd0, 3'd0, '0), mk(T_RD, 40'h40, 4'd0, 3'd0, '0), 0);

    xact("wb80", mk(T_WB, 40'h80, 4'd2, 3'd5, blk_d), mk(T_WB, 40'h80, 4'd2, 3'd5, '0), 0);
    xact("rd80", mk(T_RD, 40'h80, 4'd1, 3'd3, '0), mk(T_RD, 40'h80, 4'd1, 3'd3, blk_d), 0);

    xact("ucwr", mk(T_UC_WR, 40'hC8, 4'd3, 3'd1, blk_uc), mk(T_UC_WR, 40'hC8, 4'd3, 3'd1, '0), 0);
    xact("ucrd", mk(T_UC_RD, 40'hC8, 4'd3, 3'd1, '0), mk(T_UC_RD, 40'hC8, 4'd3, 3'd1, blk_uc_rd), 0);
    xact("rdC0", mk(T_RD, 40'hC0, 4'd0, 3'd2, '0), mk(T_RD, 40'hC0, 4'd0, 3'd2, blk_uc_c0), 0);

    xact("hold", mk(T_RD, 40'h80, 4'd7, 3'd7, '0), mk(T_RD, 40'h80, 4'd7, 3'd7, blk_d), 10);

    xact("bad", mk(T_BAD, 40'h80, 4'd5, 3'd4, ones), mk(T_BAD, 40'h80, 4'd5, 3'd4, '0), 0);
    xact("rd80b", mk(T_RD, 40'h80, 4'd0, 3'd0, '0), mk(T_RD, 40'h80, 4'd0, 3'd0, blk_d), 0);

    xact("wr40", mk(T_WR, 40'h40, 4'd1, 3'd1, blk_a), mk(T_WR, 40'h40, 4'd1, 3'd1, '0), 0);
    xact("wr4040", mk(T_WR, 40'h4040, 4'd1, 3'd1, blk_b), mk(T_WR, 40'h4040, 4'd1, 3'd1, '0), 0);
    xact("alias", mk(T_RD, 40'h40, 4'd1, 3'd1, '0), mk(T_RD, 40'h40, 4'd1, 3'd1, blk_b), 0);

    // Abort a write while it is waiting for its response.
    mem_cmd = mk(T_WR, 40'h100, 4'd0, 3'd0, blk_a);
    cmd_v   = 1'b1;
    tick();
    cmd_v   = 1'b0;
    mem_cmd = '0;
    tick();
    check("abort.in_wait", MSG_W'({resp_v, ready, busy}), MSG_W'(3'b001));
    reset = 1'b1;
    tick();
    check("abort.rst_resp_v", MSG_W'(resp_v), MSG_W'(0));
    check("abort.rst_resp", resp, MSG_W'(0));
    tick();
    reset = 1'b0;
    wait_init("reinit");
    xact("rd80z", mk(T_RD, 40'h80, 4'd0, 3'd0, '0), mk(T_RD, 40'h80, 4'd0, 3'd0, '0), 0);
    xact("rd100z", mk(T_RD, 40'h100, 4'd0, 3'd0, '0), mk(T_RD, 40'h100, 4'd0, 3'd0, '0), 0);

`ifdef BP_ME_MEM_RESPONDER_RANDOM_LATENCY_EN
    xact("rnd_wr", mk(T_WR, 40'h40, 4'd0, 3'd0, blk_d), mk(T_WR, 40'h40, 4'd0, 3'd0, '0), 0);
    for (int i = 0; i < 100; i++)
      xact("rnd_rd", mk(T_RD, 40'h40, 4'(i), 3'(i), '0), mk(T_RD, 40'h40, 4'(i), 3'(i), blk_d), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bp_me_nonsynth_mem_responder.md
Name: bp_me_nonsynth_mem_responder

Overview:
- Behavioural memory endpoint for the CCE-MEM interface in ME unit testbenches.
- Consumes mem_cmd messages that the CCE issues on its ready&valid port.
- Returns mem_resp messages on the CCE's valid->yumi inbound port after a programmable latency.
- Holds a small block-granular backing store.
- Handles cached reads and writebacks plus uncached dword reads and writes, so CCE traffic can be checked end to end.

Parameters:
- bp_params_p, e_bp_inv_cfg, processor config; supplies paddr_width_p, cce_block_width_p, dword_width_p, lce_id_width_p, lce_max_assoc_p.
- mem_els_p, 256, number of cache blocks in the backing store; must be a power of two.
- latency_p, 4, cycles from command accept to mem_resp_v_o; must be at least 1.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- mem_cmd_i  in  cce_mem_msg_width_lp  bp_cce_mem_msg_s command from the CCE.
- mem_cmd_v_i  in  1  command valid.
- mem_cmd_ready_o  out  1  responder can accept a command.
- mem_resp_o  out  cce_mem_msg_width_lp  bp_cce_mem_msg_s response to the CCE.
- mem_resp_v_o  out  1  response valid.
- mem_resp_yumi_i  in  1  CCE consumes the response; only legal while mem_resp_v_o is high.
- busy_o  out  1  high in any state other than e_ready.

Behaviour:
- Reset values: mem_cmd_ready_o=0, mem_resp_v_o=0, mem_resp_o=0, busy_o=1. State is e_init, index counter is 0, latency counter is 0.
- Block index: addr[lg_block_bytes +: lg(mem_els_p)], where lg_block_bytes = log2(cce_block_width_p/8). Upper address bits are ignored, so addresses alias modulo mem_els_p blocks.
- Dword select: addr[3 +: lg(cce_block_width_p/dword_width_p)].
- e_init: writes zero to one entry per cycle. After entry mem_els_p-1, goes to e_ready. Init takes exactly mem_els_p cycles.
- e_ready: mem_cmd_ready_o=1. On mem_cmd_v_i, the command is accepted that cycle and its effect is applied in the same cycle:
  - e_cce_mem_wb and e_cce_mem_wr: store the full data field into the block.
  - e_cce_mem_uc_wr: store data[dword_width_p-1:0] into the selected dword; other dwords are unchanged.
  - e_cce_mem_rd: capture the full block.
  - e_cce_mem_uc_rd: capture the selected dword, zero-extended to cce_block_width_p.
  - Header is captured unchanged (msg_type, addr, payload including lce_id, way_id, state, speculative).
  - Goes to e_wait with counter = latency_p-1.
- e_wait: counter decrements each cycle. At 0, goes to e_resp. mem_resp_v_o therefore rises exactly latency_p cycles after the accept edge.
- e_resp: mem_resp_v_o=1 with the captured message.
  - Write-type responses (wb, wr, uc_wr) carry data=0.
  - On mem_resp_yumi_i, goes to e_ready; a new command can be accepted the next cycle.
  - mem_resp_o is held stable while waiting.
- Only one command is outstanding at a time; ready is low in e_init, e_wait and e_resp.
- The accept-cycle capture gives read-after-write ordering for back-to-back commands to the same block.
- Unknown msg_type: the command is accepted and a response echoing the header with data=0 is returned; memory is unchanged.
- reset_i asserted mid-transaction: the in-flight response is dropped, outputs return to reset values, and init repeats.
- Nonsynth checks:
  - $error if mem_resp_yumi_i is high while mem_resp_v_o is low.
  - $error if latency_p=0.

Optional Feature:
- Macro: BP_ME_MEM_RESPONDER_RANDOM_LATENCY_EN.
- Enabled:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - On accept, the wait counter loads latency_p-1 plus LFSR[2:0], adding 0-7 extra cycles.
  - Response ordering and data are unchanged.
- Disabled: latency is exactly latency_p; no LFSR logic.

Test Plan:
- Reset release: mem_cmd_ready_o stays 0 for 256 cycles, then rises; then e_cce_mem_rd to addr 0x0000_0040 returns data=0 with mem_resp_v_o exactly 4 cycles after accept.
- wb to addr 0x80 with data=512'hDEAD..BEEF, lce_id=2, way_id=5, then rd to 0x80: first resp has msg_type=wb, data=0, lce_id=2, way_id=5; second resp has the written block, with ready=0 between accept and yumi.
- uc_wr to 0xC8, dword 64'h1122334455667788, then uc_rd to 0xC8: returns 64'h1122334455667788 zero-extended; rd to 0xC0 shows the value in dword 1 only.
- Hold mem_resp_yumi_i low for 10 cycles after valid: mem_resp_v_o and mem_resp_o stay stable and mem_cmd_ready_o stays 0; yumi pulse gives ready=1 the next cycle.
- Aliasing: write to 0x40 and 0x40+256*64, then rd to 0x40: returns the second write's data.
- Reset asserted during e_wait: mem_resp_v_o never rises, ready=0 for 256 cycles, and memory reads 0. With the macro defined, 100 reads show latencies in 4..11 with every response correct.
